// File: rtl/fpga_input_debouncer_pkg.sv
// Shared types and sizing helpers for the board-input debouncer.
package fpga_input_debouncer_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } deb_state_t;

   // Wide enough to hold STABLE_CYCLES itself.
   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchronizer, then a counter FSM that needs STABLE_CYCLES+1 matching samples.
// Latency from pin change to dout/rise/fall is 2+STABLE_CYCLES cycles; no backpressure.
module debounce_channel
   import fpga_input_debouncer_pkg::*;
#(
   parameter int   STABLE_CYCLES = 500000,
   parameter logic RST_BIT       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int              CW        = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_TGT   = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam deb_state_t      RST_STATE = RST_BIT ? STABLE_HI : STABLE_LO;

   logic          s1_q, s2_q;
   deb_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dout_q, dout_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s2_q) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!s2_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TGT) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2_q) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (s2_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TGT) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RST_STATE;
            cnt_d   = '0;
         end
      endcase
      // Registered from the next state so busy lines up with the WAIT cycles.
      busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= RST_BIT;
         s2_q    <= RST_BIT;
         state_q <= RST_STATE;
         cnt_q   <= '0;
         dout_q  <= RST_BIT;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= din;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: rtl/fpga_input_debouncer.sv
// WIDTH independent debounced board inputs with registered level, edge-event and busy outputs.
// Latency 2+STABLE_CYCLES cycles per accepted change; no backpressure.
module fpga_input_debouncer
   import fpga_input_debouncer_pkg::*;
#(
   parameter int               WIDTH         = 5,
   parameter int               STABLE_CYCLES = 500000,
   parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] busy
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RST_BIT       (RST_VAL[i])
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (din[i]),
         .dout  (dout[i]),
         .rise  (rise[i]),
         .fall  (fall[i]),
         .busy  (busy[i])
      );
   end

endmodule

// File: tb/tb_fpga_input_debouncer.sv
// Directed bench: STABLE_CYCLES=4 main instance, plus instances at 1 and at the 2^24-1 maximum.
module tb_fpga_input_debouncer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] din_m, dout_m, rise_m, fall_m, busy_m;
   logic [4:0] din_f, dout_f, rise_f, fall_f, busy_f;
   logic [4:0] din_x, dout_x, rise_x, fall_x, busy_x;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpga_input_debouncer #(.WIDTH(5), .STABLE_CYCLES(4), .RST_VAL(5'b00000)) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din_m),
      .dout(dout_m), .rise(rise_m), .fall(fall_m), .busy(busy_m));

   fpga_input_debouncer #(.WIDTH(5), .STABLE_CYCLES(1), .RST_VAL(5'b00000)) u_fast (
      .clk(clk), .rst_n(rst_n), .din(din_f),
      .dout(dout_f), .rise(rise_f), .fall(fall_f), .busy(busy_f));

   fpga_input_debouncer #(.WIDTH(5), .STABLE_CYCLES(16777215), .RST_VAL(5'b00000)) u_max (
      .clk(clk), .rst_n(rst_n), .din(din_x),
      .dout(dout_x), .rise(rise_x), .fall(fall_x), .busy(busy_x));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Step past one rising edge; afterwards "edge e" results are visible.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nr, nf, redge;
      rst_n = 1'b0;
      din_m = '0;
      din_f = '0;
      din_x = '0;

      repeat (3) begin
         tick();
         chk("rst_dout", dout_m, 5'b0);
         chk("rst_rise", rise_m, 5'b0);
         chk("rst_fall", fall_m, 5'b0);
         chk("rst_busy", busy_m, 5'b0);
         chk("rst_dout_f", dout_f, 5'b0);
         chk("rst_dout_x", dout_x, 5'b0);
      end
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk("idle_dout", dout_m, 5'b0);
         chk("idle_rise", rise_m, 5'b0);
         chk("idle_fall", fall_m, 5'b0);
         chk("idle_busy", busy_m, 5'b0);
      end

      // Clean step on channel 2: accepted at edge 6.
      din_m[2] = 1'b1;
      for (int e = 0; e < 9; e++) begin
         tick();
         chk("step_dout", dout_m, (e >= 6) ? 5'b00100 : 5'b00000);
         chk("step_rise", rise_m, (e == 6) ? 5'b00100 : 5'b00000);
         chk("step_fall", fall_m, 5'b0);
         chk("step_busy", busy_m, (e >= 2 && e <= 5) ? 5'b00100 : 5'b00000);
      end

      // Bounce on channel 0: 1x3, 0x2, then steady 1 from edge 5; rise at edge 11.
      nr = 0; nf = 0; redge = -1;
      for (int e = 0; e < 16; e++) begin
         din_m[0] = (e < 3) || (e >= 5);
         tick();
         if (rise_m[0]) begin
            nr++;
            redge = e;
         end
         if (fall_m[0]) nf++;
      end
      chk("bounce_nrise", nr, 1);
      chk("bounce_redge", redge, 11);
      chk("bounce_nfall", nf, 0);
      chk("bounce_dout", dout_m, 5'b00101);

      // 4-cycle glitch on channel 1 is rejected.
      for (int e = 0; e < 11; e++) begin
         din_m[1] = (e < 4);
         tick();
         chk("glitch_busy", busy_m, (e >= 2 && e <= 5) ? 5'b00010 : 5'b00000);
         chk("glitch_dout", dout_m, 5'b00101);
         chk("glitch_rise", rise_m, 5'b0);
         chk("glitch_fall", fall_m, 5'b0);
      end

      // Falling step on channel 2.
      din_m[2] = 1'b0;
      for (int e = 0; e < 9; e++) begin
         tick();
         chk("fallstep_dout", dout_m, (e >= 6) ? 5'b00001 : 5'b00101);
         chk("fallstep_fall", fall_m, (e == 6) ? 5'b00100 : 5'b00000);
         chk("fallstep_rise", rise_m, 5'b0);
      end

      // Reset asserted mid-WAIT_HI on channel 3, released with din still high.
      din_m[3] = 1'b1;
      repeat (4) tick();
      chk("midwait_busy", busy_m, 5'b01000);
      rst_n = 1'b0;
      #1;
      chk("midrst_dout", dout_m, 5'b0);
      chk("midrst_busy", busy_m, 5'b0);
      chk("midrst_rise", rise_m, 5'b0);
      chk("midrst_fall", fall_m, 5'b0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int e = 0; e < 9; e++) begin
         tick();
         chk("relrst_dout", dout_m, (e >= 6) ? 5'b01001 : 5'b00000);
         chk("relrst_rise", rise_m, (e == 6) ? 5'b01001 : 5'b00000);
         chk("relrst_fall", fall_m, 5'b0);
         chk("relrst_busy", busy_m, (e >= 2 && e <= 5) ? 5'b01001 : 5'b00000);
      end

      // STABLE_CYCLES=1: all channels together, accepted at edge 3.
      din_f = 5'h1F;
      for (int e = 0; e < 5; e++) begin
         tick();
         chk("fast_rise", rise_f, (e == 3) ? 5'h1F : 5'h00);
         chk("fast_dout", dout_f, (e >= 3) ? 5'h1F : 5'h00);
         chk("fast_busy", busy_f, (e == 2) ? 5'h1F : 5'h00);
         chk("fast_fall0", fall_f, 5'h00);
      end
      din_f = 5'h00;
      for (int e = 0; e < 5; e++) begin
         tick();
         chk("fast_fall", fall_f, (e == 3) ? 5'h1F : 5'h00);
         chk("fast_dout_lo", dout_f, (e >= 3) ? 5'h00 : 5'h1F);
         chk("fast_rise0", rise_f, 5'h00);
      end
      // A single-cycle pulse is shorter than two samples and must be dropped.
      din_f = 5'h1F;
      tick();
      din_f = 5'h00;
      for (int e = 1; e < 7; e++) begin
         tick();
         chk("fast_glitch_busy", busy_f, (e == 2) ? 5'h1F : 5'h00);
         chk("fast_glitch_dout", dout_f, 5'h00);
         chk("fast_glitch_rise", rise_f, 5'h00);
      end

      // Maximum STABLE_CYCLES: stays in WAIT, no premature acceptance.
      din_x = 5'h1F;
      for (int e = 0; e < 2000; e++) begin
         tick();
         chk("max_busy", busy_x, (e >= 2) ? 5'h1F : 5'h00);
         chk("max_rise", rise_x, 5'h00);
         chk("max_dout", dout_x, 5'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
